seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle signed integer divider built on restoring shift-subtract: one quotient bit per clock. It is the subtract-side counterpart to the ALU's combinational adder.
- Sits beside the ALU datapath. The control unit issues start with operands, stalls on busy, and captures quotient and remainder when done pulses.
- Truncating division, C semantics: quotient rounds toward zero; remainder takes the sign of the dividend.

Parameters:
- WIDTH, 16, operand/result width in bits (two's complement); iteration counter is $clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- enable  input  1  1 = FSM advances; 0 = FSM and datapath hold state
- start  input  1  request; sampled only in IDLE with enable=1
- a  input  WIDTH  dividend, signed
- b  input  WIDTH  divisor, signed
- busy  output  1  1 in any state other than IDLE
- done  output  1  one-cycle completion pulse
- q  output  WIDTH  quotient, signed, registered
- r  output  WIDTH  remainder, signed, registered
- div_by_zero  output  1  registered; updated with each done

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, q=0, r=0, div_by_zero=0; internal registers cleared. Reset mid-operation aborts the divide with no done pulse.
- States: IDLE, SETUP, DIVIDE, FIXUP.
  - IDLE: on edge with enable=1 and start=1, latch a/b and go to SETUP.
  - SETUP: capture |a| and |b| as unsigned WIDTH-bit magnitudes (|-2^(W-1)| = 2^(W-1) fits unsigned); record neg_q = sign(a)^sign(b) and neg_r = sign(a). If b==0 go to FIXUP, else load count=WIDTH and go to DIVIDE.
  - DIVIDE: per edge, shift {rem,dvd} left by 1, trial = rem - |b|. If trial is non-negative, rem = trial and the quotient LSB is 1; otherwise rem is unchanged and the LSB is 0. Decrement count; on the edge where count reaches 0, go to FIXUP. Exactly WIDTH iterations.
  - FIXUP: q = neg_q ? -mag_q : mag_q; r = neg_r ? -mag_r : mag_r, both mod 2^WIDTH. Pulse done=1 and go to IDLE.
- Divide by zero: q = all ones (-1), r = a unchanged, div_by_zero=1. Any normal completion clears div_by_zero to 0.
- Overflow: a = -2^(W-1), b = -1 gives q = -2^(W-1) (wraps), r=0, no flag.
- Latency, counted in enabled edges after the start-sampling edge E0:
  - done is high for the cycle following edge E(WIDTH+2); 18 edges for WIDTH=16.
  - For b==0, done is high following edge E2.
- enable=0 freezes state, counter and datapath registers; latency extends by one edge per stalled edge.
- done is high exactly one cycle and clears on the next edge regardless of enable.
- q, r and div_by_zero hold their values until the next FIXUP; they change only in FIXUP.
- start while busy=1 is ignored, not queued. start in the same cycle that done is high is accepted, since the FSM is in IDLE.
- a/b may change after E0 without effect.

Optional Feature:
- Macro: SEQ_DIVIDER_UNSIGNED_EN.
- Defined: adds input port sign_mode (1 bit), sampled with start.
  - sign_mode=1: signed behaviour as above.
  - sign_mode=0: a and b are unsigned; SETUP skips the absolute-value step; neg_q = neg_r = 0. Divide-by-zero gives q = all ones and r = a.
- Not defined: no sign_mode port; always signed.

Test Plan:
- a=100, b=7, start one cycle, enable=1 -> busy for 18 edges; done pulse 18 edges after start; q=14, r=2, div_by_zero=0.
- a=-100, b=7 -> q=-14 (0xFFF2), r=-2 (0xFFFE). Then a=100, b=-7 -> q=-14, r=2. Then a=-100, b=-7 -> q=14, r=-2.
- a=100, b=0 -> done 2 edges after start; q=0xFFFF, r=100, div_by_zero=1. Then a=9, b=3 -> q=3, r=0, div_by_zero=0.
- a=0x8000, b=0xFFFF -> q=0x8000, r=0.
  - Same case with SEQ_DIVIDER_UNSIGNED_EN and sign_mode=0 -> q=0x0000, r=0x8000.
- a=1000, b=3, enable=0 for 5 cycles mid-DIVIDE, start re-asserted while busy -> done 23 edges after the first start; q=333, r=1; single done pulse.
- Start a divide, assert reset=0 asynchronously at edge 8 for 2 cycles -> all outputs 0 immediately, no done. Restart with a=50, b=5 -> q=10, r=0 after 18 edges.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed restoring divider, one quotient bit per enabled clock.
// Truncating (C) semantics: quotient rounds toward zero, remainder takes the dividend's sign.
// Optional macro SEQ_DIVIDER_UNSIGNED_EN adds a sign_mode input (1 = signed, 0 = unsigned).
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   enable       1 = FSM/datapath advance, 0 = hold
//   start        request, sampled in IDLE with enable=1
//   a, b         dividend / divisor (WIDTH bits)
//   sign_mode    (macro only) operand signedness, sampled with start
//   busy         high whenever the FSM is not in IDLE
//   done         one-cycle completion pulse
//   q, r         registered quotient / remainder
//   div_by_zero  registered flag, updated with each done
module seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
`ifdef SEQ_DIVIDER_UNSIGNED_EN
  input  logic             sign_mode,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    DIVIDE = 2'd2,
    FIXUP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic             signed_lat;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [CW-1:0]    count;
  logic             neg_q;
  logic             neg_r;

  logic             busy_next;
  logic             done_next;

  logic             signed_req;
  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;
  logic [WIDTH:0]   shifted_c;
  logic [WIDTH-1:0] trial_c;
  logic             take_c;

`ifdef SEQ_DIVIDER_UNSIGNED_EN
  assign signed_req = sign_mode;
`else
  assign signed_req = 1'b1;
`endif

  // Operand magnitudes; the most negative value maps onto 2^(W-1), which fits unsigned.
  always_comb begin
    mag_a_c = a_lat;
    mag_b_c = b_lat;
    if (signed_lat && a_lat[WIDTH-1]) mag_a_c = WIDTH'(-a_lat);
    if (signed_lat && b_lat[WIDTH-1]) mag_b_c = WIDTH'(-b_lat);
  end

  // One restoring step. shifted_c needs an extra bit since rem may reach 2^W-2 in unsigned mode;
  // when the subtraction is taken the true difference is below mag_b, so W bits hold it exactly.
  always_comb begin
    shifted_c = {rem, dvd[WIDTH-1]};
    take_c    = (shifted_c >= {1'b0, mag_b});
    trial_c   = shifted_c[WIDTH-1:0] - mag_b;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    if (enable) begin
      case (state)
        IDLE:    if (start) state_next = SETUP;
        SETUP:   state_next = (b_lat == '0) ? FIXUP : DIVIDE;
        DIVIDE:  if (count == CW'(1)) state_next = FIXUP;
        FIXUP:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode, registered below so busy/done come straight from flops.
  always_comb begin
    busy_next = (state_next != IDLE);
    done_next = enable && (state == FIXUP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_next;
      done <= done_next;
    end
  end

  // Datapath: operand capture, iteration and sign fixup.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_lat       <= '0;
      b_lat       <= '0;
      signed_lat  <= 1'b0;
      mag_b       <= '0;
      rem         <= '0;
      dvd         <= '0;
      count       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (start) begin
            a_lat      <= a;
            b_lat      <= b;
            signed_lat <= signed_req;
          end
        end
        SETUP: begin
          mag_b <= mag_b_c;
          dvd   <= mag_a_c;
          rem   <= '0;
          count <= CW'(WIDTH);
          neg_q <= signed_lat && (a_lat[WIDTH-1] ^ b_lat[WIDTH-1]);
          neg_r <= signed_lat && a_lat[WIDTH-1];
        end
        DIVIDE: begin
          rem   <= take_c ? trial_c : shifted_c[WIDTH-1:0];
          dvd   <= {dvd[WIDTH-2:0], take_c};
          count <= count - CW'(1);
        end
        FIXUP: begin
          if (b_lat == '0) begin
            q           <= '1;
            r           <= a_lat;
            div_by_zero <= 1'b1;
          end else begin
            q           <= neg_q ? WIDTH'(-dvd) : dvd;
            r           <= neg_r ? WIDTH'(-rem) : rem;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven and hand-sequenced checks of seq_divider with a result scoreboard.
module tb_seq_divider;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         start;
  logic         sign_mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         div_by_zero;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .start       (start),
`ifdef SEQ_DIVIDER_UNSIGNED_EN
    .sign_mode   (sign_mode),
`endif
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .q           (q),
    .r           (r),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           e0;
    int           lat;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sm;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vsm,
                              input logic [W-1:0] vq, input logic [W-1:0] vr, input logic vdz,
                              input int vlat);
    vec_t v;
    v.a = va; v.b = vb; v.sm = vsm; v.q = vq; v.r = vr; v.dz = vdz; v.lat = vlat;
    return v;
  endfunction

  // Independent signed reference using 32-bit integer division (truncates toward zero).
  function automatic vec_t model(input logic [W-1:0] va, input logic [W-1:0] vb);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sbv;
    int ia, ib, iq, ir;
    sa  = va;
    sbv = vb;
    ia  = int'(sa);
    ib  = int'(sbv);
    iq  = ia / ib;
    ir  = ia % ib;
    return mk(va, vb, 1'b1, W'(iq), W'(ir), 1'b0, W + 2);
  endfunction

  // Result monitor: pops the scoreboard on each done pulse, sampled just after the edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (done) begin
      chk("done_single_cycle", 32'(prev_done), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("q", 32'(q), 32'(mon_e.q));
        chk("r", 32'(r), 32'(mon_e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(mon_e.dz));
        chk("latency", 32'(cyc - mon_e.e0), 32'(mon_e.lat));
      end
    end
    prev_done = done;
  end

  task automatic wait_empty(input string name);
    for (int i = 0; i < 80; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=pending required=done (t=%0t)", name, $time);
      sb.delete();
    end
  endtask

  // Issue one divide starting at the current negedge; returns at the negedge while done is high.
  task automatic run(input vec_t v);
    exp_t e;
    a = v.a; b = v.b; sign_mode = v.sm; start = 1'b1;
    e.q = v.q; e.r = v.r; e.dz = v.dz; e.e0 = cyc + 1; e.lat = v.lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_empty("run");
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; start = 1'b0; sign_mode = 1'b1; a = '0; b = '0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_q", 32'(q), 32'd0);
    chk("reset_r", 32'(r), 32'd0);
    chk("reset_dz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    tbl.push_back(mk(16'd100,   16'd7,     1'b1, 16'd14,    16'd2,    1'b0, 18));
    tbl.push_back(mk(-16'sd100, 16'd7,     1'b1, 16'hFFF2,  16'hFFFE, 1'b0, 18));
    tbl.push_back(mk(16'd100,   -16'sd7,   1'b1, 16'hFFF2,  16'd2,    1'b0, 18));
    tbl.push_back(mk(-16'sd100, -16'sd7,   1'b1, 16'd14,    16'hFFFE, 1'b0, 18));
    tbl.push_back(mk(16'd100,   16'd0,     1'b1, 16'hFFFF,  16'd100,  1'b1, 2));
    tbl.push_back(mk(16'd9,     16'd3,     1'b1, 16'd3,     16'd0,    1'b0, 18));
    tbl.push_back(mk(16'h8000,  16'hFFFF,  1'b1, 16'h8000,  16'd0,    1'b0, 18));
    tbl.push_back(mk(16'h7FFF,  16'd1,     1'b1, 16'h7FFF,  16'd0,    1'b0, 18));
    tbl.push_back(mk(16'hFFFF,  16'h8000,  1'b1, 16'd0,     16'hFFFF, 1'b0, 18));
    tbl.push_back(mk(16'h8000,  16'd0,     1'b1, 16'hFFFF,  16'h8000, 1'b1, 2));
    tbl.push_back(mk(16'd7,     -16'sd100, 1'b1, 16'd0,     16'd7,    1'b0, 18));
`ifdef SEQ_DIVIDER_UNSIGNED_EN
    tbl.push_back(mk(16'h8000,  16'hFFFF,  1'b0, 16'd0,     16'h8000, 1'b0, 18));
    tbl.push_back(mk(16'hFFFF,  16'd2,     1'b0, 16'h7FFF,  16'd1,    1'b0, 18));
    tbl.push_back(mk(16'hFFFF,  16'd0,     1'b0, 16'hFFFF,  16'hFFFF, 1'b1, 2));
    tbl.push_back(mk(16'hFFF9,  16'hFFFE,  1'b1, 16'd3,     16'hFFFF, 1'b0, 18));
`endif
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (rb == '0) rb = 16'd5;
      tbl.push_back(model(ra, rb));
    end

    // Back-to-back: each run starts in the cycle the previous done is high.
    foreach (tbl[i]) run(tbl[i]);

    // Stall mid-DIVIDE for 5 cycles while start is held; the held start must be ignored.
    @(negedge clk);
    sign_mode = 1'b1;
    a = 16'd1000; b = 16'd3; start = 1'b1;
    begin
      exp_t e;
      e.q = 16'd333; e.r = 16'd1; e.dz = 1'b0; e.e0 = cyc + 1; e.lat = 23;
      sb.push_back(e);
    end
    @(negedge clk);
    a = 16'd7; b = 16'd1;
    repeat (4) @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    chk("busy_after_stall", 32'(busy), 32'd1);
    wait_empty("stall");
    repeat (5) @(negedge clk);
    chk("idle_after_stall", 32'(busy), 32'd0);
    chk("no_queued_start", 32'(sb.size()), 32'd0);

    // Asynchronous reset partway through a divide aborts it without a done pulse.
    a = 16'd1000; b = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_r", 32'(r), 32'd0);
    chk("abort_dz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run(mk(16'd50, 16'd5, 1'b1, 16'd10, 16'd0, 1'b0, 18));
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
